mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-access stage controller sitting between the ALU-output/register-B latches and the byte-addressed data memory of the multicycle CPU.
- Sequences word, half-word and byte loads and stores against the word-wide, big-endian data memory; byte and half stores use read-modify-write.
- Latches and sign/zero-extends load results into the memory data register (MDR) consumed by the write-back stage.
- Reports misaligned or out-of-range accesses to the control unit.

Parameters:
- MEM_BYTES, 128, data memory size in bytes; a legal word-aligned address is at most MEM_BYTES-4.
- RD_LAT, 1, clock cycles from read address valid to datMemOut valid; legal values are 1 to 4.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request from the control unit; sampled only in IDLE.
- memOp  in  3  access type: 000 lb, 001 lh, 010 lw, 011 sb, 100 lbu, 101 lhu, 110 sh, 111 sw.
- aluOOut  in  32  byte address.
- regBOut  in  32  store data; the byte or half is taken from the low bits.
- datMemOut  in  32  read word from data memory.
- datMemWr  out  1  data memory write enable.
- datMemAddr  out  32  word-aligned address to data memory.
- datMemWrData  out  32  write word to data memory.
- mdrOut  out  32  extended load result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- accErr  out  1  one-cycle error flag, coincident with done.

Behaviour:
- Reset: state goes to IDLE. datMemWr, busy, done and accErr are 0. datMemAddr, datMemWrData and mdrOut are 0. Reset applies immediately, including mid-operation, so no write completes after rst rises.
- Byte lanes are big-endian. Byte offset k = addr[1:0] selects bits [31-8k:24-8k]. Half offset h = addr[1] selects bits [31-16h:16-16h]. datMemAddr = {addr[31:2], 2'b00}.
- IDLE, start=1: latch memOp, aluOOut and regBOut.
  - Error when a half access has addr[0]=1, a word access has addr[1:0]≠0, or the aligned address exceeds MEM_BYTES-4. Go to DONE with accErr set.
  - Otherwise loads and sb/sh go to READ; sw goes to WRITE.
- start while busy is ignored; the latched operands do not change.
- READ: datMemWr=0, datMemAddr driven. A counter runs RD_LAT cycles. On the last cycle, capture datMemOut:
  - Loads: mdrOut = selected lane. lb/lh sign-extend; lbu/lhu zero-extend; lw takes the full word. Next state DONE.
  - sb/sh: merge word = captured word with the selected lane replaced by regBOut[7:0] or regBOut[15:0]. Next state WRITE.
- WRITE: datMemWr=1 for exactly one cycle. datMemWrData = regBOut for sw, the merge word for sb/sh. Next state DONE.
- DONE: done=1 for one cycle, accErr as latched, then IDLE. datMemWr=0.
- mdrOut changes only on load capture. It holds across stores, errors and idle cycles.
- Latency from the start edge to the done cycle, at RD_LAT=1:
  - Load: 2 cycles (READ, DONE).
  - sw: 2 cycles.
  - sb/sh: 3 cycles.
  - Error: 1 cycle.
  - Each added RD_LAT cycle adds one cycle to READ.
- datMemWr is never asserted on an errored access.
- A start sampled in the same cycle that done is high is ignored; start is accepted only in IDLE.

Test Plan:
- Memory word at 0x10 = 0x8899AABB, lb 0x11 -> done after 2 cycles, mdrOut = 0xFFFFFF99; lbu 0x11 -> mdrOut = 0x00000099.
- Same word, lh 0x12 -> mdrOut = 0xFFFFAABB; lw 0x10 -> mdrOut = 0x8899AABB, datMemWr stays 0 throughout.
- sb 0x13 with regBOut = 0x123456CC over word 0x8899AABB -> one read, then one datMemWr pulse with datMemWrData = 0x8899AACC; done 3 cycles after start; mdrOut unchanged.
- lw 0x12, sh 0x11, and sw 0x7C with MEM_BYTES=128 -> lw 0x12 and sh 0x11 give done and accErr 1 cycle after start with no datMemWr; sw 0x7C is legal; lw 0x80 sets accErr.
- Assert rst during the WRITE state of sb -> datMemWr drops immediately, all outputs return to 0, state is IDLE; the next lw 0x10 completes normally.
- start pulsed again while busy with a different address, and RD_LAT=3 -> second request ignored; lw done 4 cycles after start with the first address's data.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Bus between the memory-access stage and its environment: control-unit request,
// data-memory port, MDR result and status. The slave side is the access unit.
interface mem_access_unit_if;
  logic        start;
  logic [2:0]  memOp;
  logic [31:0] aluOOut;
  logic [31:0] regBOut;
  logic [31:0] datMemOut;
  logic        datMemWr;
  logic [31:0] datMemAddr;
  logic [31:0] datMemWrData;
  logic [31:0] mdrOut;
  logic        busy;
  logic        done;
  logic        accErr;
  logic [1:0]  state_dbg;

  // Handshake: start is a one-cycle request taken only while busy=0; the unit
  // answers with exactly one done pulse (accErr valid in the same cycle) and
  // ignores start until it has returned to idle after that pulse.
  modport master (
    output start, memOp, aluOOut, regBOut, datMemOut,
    input  datMemWr, datMemAddr, datMemWrData, mdrOut, busy, done, accErr, state_dbg
  );
  modport slave (
    input  start, memOp, aluOOut, regBOut, datMemOut,
    output datMemWr, datMemAddr, datMemWrData, mdrOut, busy, done, accErr, state_dbg
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access stage: big-endian byte/half/word loads and stores against a
// word-wide data memory, read-modify-write for sub-word stores, MDR extension.
module mem_access_unit #(
  parameter int MEM_BYTES = 128,
  parameter int RD_LAT    = 1
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  localparam logic [1:0]  CNT_LAST = 2'(RD_LAT - 1);
  localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] regb_q, regb_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] mdr_q, mdr_d;
  logic        err_q, err_d;
  logic [1:0]  cnt_q, cnt_d;

  function automatic logic is_half(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b101) || (op == 3'b110);
  endfunction

  function automatic logic is_word(input logic [2:0] op);
    return (op == 3'b010) || (op == 3'b111);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
  endfunction

  logic        req_err;
  logic [4:0]  byte_sh, half_sh;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val, merge_val;

  assign req_err = (is_half(bus.memOp) && bus.aluOOut[0]) ||
                   (is_word(bus.memOp) && (bus.aluOOut[1:0] != 2'b00)) ||
                   ({bus.aluOOut[31:2], 2'b00} > ADDR_MAX);

  // Big-endian lanes: offset 0 is the most significant byte/half of the word.
  assign byte_sh   = {~addr_q[1:0], 3'b000};
  assign half_sh   = {~addr_q[1], 4'b0000};
  assign byte_lane = 8'(bus.datMemOut >> byte_sh);
  assign half_lane = 16'(bus.datMemOut >> half_sh);

  always_comb begin
    load_val = bus.datMemOut;
    case (op_q)
      3'b000:  load_val = {{24{byte_lane[7]}}, byte_lane};
      3'b100:  load_val = {24'b0, byte_lane};
      3'b001:  load_val = {{16{half_lane[15]}}, half_lane};
      3'b101:  load_val = {16'b0, half_lane};
      default: load_val = bus.datMemOut;
    endcase
  end

  always_comb begin
    if (op_q == 3'b011)
      merge_val = (bus.datMemOut & ~(32'h0000_00FF << byte_sh)) | ({24'b0, regb_q[7:0]} << byte_sh);
    else
      merge_val = (bus.datMemOut & ~(32'h0000_FFFF << half_sh)) | ({16'b0, regb_q} << half_sh);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    regb_d  = regb_q;
    wdat_d  = wdat_q;
    mdr_d   = mdr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d   = bus.memOp;
          addr_d = bus.aluOOut;
          regb_d = bus.regBOut[15:0];
          err_d  = req_err;
          cnt_d  = 2'd0;
          if (req_err) begin
            state_d = DONE;
          end else if (bus.memOp == 3'b111) begin
            wdat_d  = bus.regBOut;
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (cnt_q == CNT_LAST) begin
          if (is_store(op_q)) begin
            wdat_d  = merge_val;
            state_d = WRITE;
          end else begin
            mdr_d   = load_val;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      addr_q  <= 32'b0;
      regb_q  <= 16'b0;
      wdat_q  <= 32'b0;
      mdr_q   <= 32'b0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      regb_q  <= regb_d;
      wdat_q  <= wdat_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status and the write strobe decode straight from the state register so an
  // asynchronous reset removes them in the same instant.
  assign bus.datMemWr    = (state_q == WRITE);
  assign bus.datMemAddr  = {addr_q[31:2], 2'b00};
  assign bus.datMemWrData = wdat_q;
  assign bus.mdrOut      = mdr_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.accErr      = (state_q == DONE) && err_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (read latency 1 and 3) sharing one
// memory, checked against a byte-array reference model of the memory stage.
module tb_mem_access_unit;
  localparam int MEM_BYTES = 128;

  logic clk = 1'b0;
  logic rst;
  logic init_mem;
  always #5 clk = ~clk;

  mem_access_unit_if ifa();
  mem_access_unit_if ifb();

  mem_access_unit #(.MEM_BYTES(MEM_BYTES), .RD_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  mem_access_unit #(.MEM_BYTES(MEM_BYTES), .RD_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  logic [31:0] mem     [32];
  logic [31:0] ref_mem [32];
  logic [31:0] exp_mdr [2];
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  assign ifa.datMemOut = mem[ifa.datMemAddr[6:2]];
  assign ifb.datMemOut = mem[ifb.datMemAddr[6:2]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= ref_mem[i];
    end else begin
      if (ifa.datMemWr) mem[ifa.datMemAddr[6:2]] <= ifa.datMemWrData;
      if (ifb.datMemWr) mem[ifb.datMemAddr[6:2]] <= ifb.datMemWrData;
    end
  end

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int which, input logic st, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] rb);
    if (which == 0) begin
      ifa.start = st; ifa.memOp = op; ifa.aluOOut = addr; ifa.regBOut = rb;
    end else begin
      ifb.start = st; ifb.memOp = op; ifb.aluOOut = addr; ifb.regBOut = rb;
    end
  endtask

  task automatic get_obs(input int which, output logic wr, output logic dn, output logic acc,
                         output logic bsy, output logic [31:0] addr, output logic [31:0] wd,
                         output logic [31:0] mdr, output logic [1:0] st);
    if (which == 0) begin
      wr = ifa.datMemWr; dn = ifa.done; acc = ifa.accErr; bsy = ifa.busy;
      addr = ifa.datMemAddr; wd = ifa.datMemWrData; mdr = ifa.mdrOut; st = ifa.state_dbg;
    end else begin
      wr = ifb.datMemWr; dn = ifb.done; acc = ifb.accErr; bsy = ifb.busy;
      addr = ifb.datMemAddr; wd = ifb.datMemWrData; mdr = ifb.mdrOut; st = ifb.state_dbg;
    end
  endtask

  // Runs one access; poke_at > 0 pulses start again in that cycle of the access.
  task automatic do_op(input int which, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] rb, input int poke_at);
    int rd_lat, sz, k, idx, exp_lat, exp_wr, cyc, writes;
    bit st, sgn, err;
    logic [7:0]  b [4];
    logic [31:0] w, wd, oaddr, mdr;
    logic owr, odn, oacc, obsy;
    logic [1:0] ost;

    rd_lat = (which == 0) ? 1 : 3;
    sz  = (op == 3'd0 || op == 3'd3 || op == 3'd4) ? 1 : (op == 3'd1 || op == 3'd5 || op == 3'd6) ? 2 : 4;
    st  = (op == 3'd3 || op == 3'd6 || op == 3'd7);
    sgn = (op == 3'd0 || op == 3'd1);
    err = ((addr % sz) != 0) || ((addr & 32'hFFFF_FFFC) > 32'(MEM_BYTES - 4));
    k   = int'(addr[1:0]);
    idx = int'(addr[6:2]);
    exp_wr = (!err && st) ? 1 : 0;
    if (err) exp_lat = 1;
    else if (!st) exp_lat = 1 + rd_lat;
    else exp_lat = (sz == 4) ? 2 : 2 + rd_lat;

    if (!err) begin
      w = ref_mem[idx];
      for (int i = 0; i < 4; i++) b[i] = w[31 - 8*i -: 8];
      if (!st) begin
        if (sz == 1) exp_mdr[which] = (sgn && b[k][7]) ? {24'hFFFFFF, b[k]} : {24'h0, b[k]};
        else if (sz == 2) exp_mdr[which] = (sgn && b[k][7]) ? {16'hFFFF, b[k], b[k+1]} : {16'h0, b[k], b[k+1]};
        else exp_mdr[which] = w;
      end else begin
        if (sz == 1) b[k] = rb[7:0];
        else if (sz == 2) begin b[k] = rb[15:8]; b[k+1] = rb[7:0]; end
        w = (sz == 4) ? rb : {b[0], b[1], b[2], b[3]};
        ref_mem[idx] = w;
        exp_q.push_back(w);
      end
    end

    @(negedge clk);
    set_req(which, 1'b1, op, addr, rb);
    @(negedge clk);
    cyc = 1;
    writes = 0;
    odn = 1'b0; oacc = 1'b0; mdr = '0;
    while (cyc <= 20) begin
      set_req(which, (cyc == poke_at), 3'($urandom), $urandom, $urandom);
      get_obs(which, owr, odn, oacc, obsy, oaddr, wd, mdr, ost);
      if (owr) begin
        writes++;
        check32("wr_addr", oaddr, addr & 32'hFFFF_FFFC);
        if (exp_q.size() == 0) check32("unexpected_wr", wd, 32'hxxxx_xxxx);
        else check32("wr_data", wd, exp_q.pop_front());
      end
      if (odn) break;
      @(negedge clk);
      cyc++;
    end
    check32("latency", 32'(cyc), 32'(exp_lat));
    check32("acc_err", {31'b0, oacc}, {31'b0, err});
    check32("mdr", mdr, exp_mdr[which]);
    check32("wr_count", 32'(writes), 32'(exp_wr));
    if (exp_q.size() != 0) begin
      check32("missing_wr", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
    set_req(which, 1'b0, 3'($urandom), $urandom, $urandom);
    get_obs(which, owr, odn, oacc, obsy, oaddr, wd, mdr, ost);
    check32("idle_after_done", {30'b0, obsy, odn}, 32'd0);
    if (!err) check32("mem_word", mem[idx], ref_mem[idx]);
  endtask

  task automatic reset_during_write();
    logic [31:0] oaddr, wd, mdr;
    logic owr, odn, oacc, obsy;
    logic [1:0] ost;
    @(negedge clk);
    set_req(0, 1'b1, 3'd3, 32'h13, 32'h123456CC);
    @(negedge clk);
    set_req(0, 1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    get_obs(0, owr, odn, oacc, obsy, oaddr, wd, mdr, ost);
    check32("pre_rst_wr", {31'b0, owr}, 32'd1);
    check32("pre_rst_wdata", wd, 32'h8899AACC);
    rst = 1'b1;
    #1;
    get_obs(0, owr, odn, oacc, obsy, oaddr, wd, mdr, ost);
    check32("rst_flags", {26'b0, ost, owr, odn, oacc, obsy}, 32'd0);
    check32("rst_addr", oaddr, 32'd0);
    check32("rst_wdata", wd, 32'd0);
    check32("rst_mdr", mdr, 32'd0);
    exp_mdr[0] = 32'd0;
    exp_mdr[1] = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    check32("rst_no_write", mem[4], ref_mem[4]);
  endtask

  initial begin
    logic [31:0] oaddr, wd, mdr;
    logic owr, odn, oacc, obsy;
    logic [1:0] ost;
    rst = 1'b1;
    init_mem = 1'b1;
    set_req(0, 1'b0, 3'd0, 32'h0, 32'h0);
    set_req(1, 1'b0, 3'd0, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'h8899AABB;
    exp_mdr[0] = 32'd0;
    exp_mdr[1] = 32'd0;
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    for (int u = 0; u < 2; u++) begin
      get_obs(u, owr, odn, oacc, obsy, oaddr, wd, mdr, ost);
      check32("reset_flags", {26'b0, ost, owr, odn, oacc, obsy}, 32'd0);
      check32("reset_outs", oaddr | wd | mdr, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(0, 3'd0, 32'h11, 32'h0, 0);
    check32("lb_0x11", ifa.mdrOut, 32'hFFFFFF99);
    do_op(0, 3'd4, 32'h11, 32'h0, 0);
    check32("lbu_0x11", ifa.mdrOut, 32'h00000099);
    do_op(0, 3'd1, 32'h12, 32'h0, 0);
    check32("lh_0x12", ifa.mdrOut, 32'hFFFFAABB);
    do_op(0, 3'd2, 32'h10, 32'h0, 0);
    check32("lw_0x10", ifa.mdrOut, 32'h8899AABB);
    do_op(0, 3'd3, 32'h13, 32'h123456CC, 0);
    check32("sb_0x13_mem", mem[4], 32'h8899AACC);
    check32("sb_keeps_mdr", ifa.mdrOut, 32'h8899AABB);
    do_op(0, 3'd2, 32'h12, 32'h0, 0);
    do_op(0, 3'd6, 32'h11, 32'hBEEF, 0);
    do_op(0, 3'd7, 32'h7C, 32'hCAFEF00D, 0);
    do_op(0, 3'd2, 32'h80, 32'h0, 0);

    // Re-arm the memory word for the mid-write reset scenario.
    ref_mem[4] = 32'h8899AABB;
    do_op(0, 3'd7, 32'h10, 32'h8899AABB, 0);
    reset_during_write();
    do_op(0, 3'd2, 32'h10, 32'h0, 0);

    do_op(1, 3'd2, 32'h10, 32'h0, 1);
    check32("busy_start_ignored", ifb.mdrOut, 32'h8899AABB);
    do_op(0, 3'd2, 32'h14, 32'h0, 2);

    for (int n = 0; n < 200; n++)
      do_op($urandom_range(0, 1), 3'($urandom), 32'($urandom_range(0, 135)), $urandom,
            $urandom_range(0, 5));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
